// File: rtl/sat_accum_pkg.sv
// sat_accum_pkg: shared width helpers and FSM state type for the saturating accumulator.
package sat_accum_pkg;
  typedef enum logic {IDLE, ACCUM} state_t;
  function automatic int clog2(input int n);
    int r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < n) r = i + 1;
    return r;
  endfunction
  function automatic int acc_w(input int in_w, input int acc_len);
    return in_w + clog2(acc_len) + 1;
  endfunction
  // Beat counter needs at least one bit even when a group is a single beat.
  function automatic int cnt_w(input int acc_len);
    return clog2(acc_len) > 0 ? clog2(acc_len) : 1;
  endfunction
endpackage

// File: rtl/sat_clip.sv
// sat_clip: clips a wide signed sum to OUT_W bits with a saturation flag; SAT_ACCUM_RELU_EN zeroes negatives.
module sat_clip #(
  parameter int ACC_W = 37,
  parameter int OUT_W = 8
) (
  input  logic signed [ACC_W-1:0] sum,
  output logic        [OUT_W-1:0] res,
  output logic                    sat
);
  localparam logic signed [ACC_W-1:0] HI = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  logic pos;
  assign pos = sum > HI;
`ifdef SAT_ACCUM_RELU_EN
  always_comb begin
    res = sum[ACC_W-1] ? '0 : pos ? HI[OUT_W-1:0] : sum[OUT_W-1:0];
    sat = pos;
  end
`else
  localparam logic signed [ACC_W-1:0] LO = ~HI;
  logic neg;
  assign neg = sum < LO;
  always_comb begin
    res = pos ? HI[OUT_W-1:0] : neg ? LO[OUT_W-1:0] : sum[OUT_W-1:0];
    sat = pos || neg;
  end
`endif
endmodule

// File: rtl/sat_accum.sv
// sat_accum: multi-channel grouped saturating accumulator with valid/ready on both sides.
// Optional SAT_ACCUM_RELU_EN macro selects ReLU clipping in sat_clip.
module sat_accum
  import sat_accum_pkg::*;
#(
  parameter int IN_W    = 32,
  parameter int OUT_W   = 8,
  parameter int CH      = 4,
  parameter int ACC_LEN = 9
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CH*IN_W-1:0]  in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CH*OUT_W-1:0] out_data,
  output logic [CH-1:0]       out_sat
);
  localparam int AW = acc_w(IN_W, ACC_LEN);
  localparam int CW = cnt_w(ACC_LEN);
  state_t state, state_d;
  logic [CW-1:0] cnt;
  logic fire, close;
  logic [CH*OUT_W-1:0] clip_d;
  logic [CH-1:0] sat_d;
  assign in_ready = !(out_valid && !out_ready);
  // A beat offered alongside clr is dropped, never counted.
  assign fire  = in_valid && in_ready && !clr;
  assign close = fire && cnt == CW'(ACC_LEN - 1);
  always_comb state_d = clr ? IDLE : fire ? (close ? IDLE : ACCUM) : state;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= (clr || close) ? '0 : fire ? cnt + 1'b1 : cnt;
    end
  end
  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic signed [AW-1:0] acc, sum;
    assign sum = acc + {{(AW-IN_W){in_data[c*IN_W+IN_W-1]}}, in_data[c*IN_W +: IN_W]};
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) acc <= '0;
      else if (clr || close) acc <= '0;
      else if (fire) acc <= sum;
    end
    sat_clip #(.ACC_W(AW), .OUT_W(OUT_W)) u_clip (
      .sum(sum),
      .res(clip_d[c*OUT_W +: OUT_W]),
      .sat(sat_d[c])
    );
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= '0;
    end else if (close) begin
      out_valid <= 1'b1;
      out_data  <= clip_d;
      out_sat   <= sat_d;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_sat_accum.sv
// tb_sat_accum: randomized and directed checks of sat_accum against a cycle-level arithmetic model.
module tb_sat_accum;
  localparam int IN_W = 32, OUT_W = 8, CH = 4, ACC_LEN = 9;
  localparam longint MAXO = (64'sd1 <<< (OUT_W - 1)) - 1;
  localparam longint MINO = -(64'sd1 <<< (OUT_W - 1));
  logic clk = 0, rst_n = 0, clr = 0, in_valid = 0, out_ready = 1;
  logic [CH*IN_W-1:0] in_data = '0;
  logic in_ready, out_valid;
  logic [CH*OUT_W-1:0] out_data;
  logic [CH-1:0] out_sat;
  int checks = 0, errors = 0;
  longint sum [CH];
  longint exp_v [CH];
  bit exp_s [CH];
  int n = 0;
  bit mv = 0;
  int vals [CH];

  sat_accum #(.IN_W(IN_W), .OUT_W(OUT_W), .CH(CH), .ACC_LEN(ACC_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      sum[c] = 0; exp_v[c] = 0; exp_s[c] = 0;
    end
    n = 0; mv = 0;
  endtask

  task automatic clip(input longint s, output longint v, output bit sat);
`ifdef SAT_ACCUM_RELU_EN
    if (s < 0) begin v = 0; sat = 0; end
`else
    if (s < MINO) begin v = MINO; sat = 1; end
`endif
    else if (s > MAXO) begin v = MAXO; sat = 1; end
    else begin v = s; sat = 0; end
  endtask

  task automatic check_out();
    check("out_valid", out_valid, mv);
    if (mv)
      for (int c = 0; c < CH; c++) begin
        check($sformatf("data%0d", c), longint'($signed(out_data[c*OUT_W +: OUT_W])), exp_v[c]);
        check($sformatf("sat%0d", c), out_sat[c], exp_s[c]);
      end
  endtask

  // One clock: drive inputs, predict, clock, compare.
  task automatic cyc(input bit v, input bit c_clr, input bit ordy);
    bit rdy, fire;
    in_valid = v; clr = c_clr; out_ready = ordy;
    for (int c = 0; c < CH; c++) in_data[c*IN_W +: IN_W] = vals[c];
    #1;
    rdy = !(mv && !ordy);
    check("in_ready", in_ready, rdy);
    fire = v && rdy;
    if (c_clr) begin
      for (int c = 0; c < CH; c++) sum[c] = 0;
      n = 0;
      if (mv && ordy) mv = 0;
    end else if (fire && n == ACC_LEN - 1) begin
      for (int c = 0; c < CH; c++) begin
        clip(sum[c] + longint'(vals[c]), exp_v[c], exp_s[c]);
        sum[c] = 0;
      end
      n = 0; mv = 1;
    end else begin
      if (fire) begin
        for (int c = 0; c < CH; c++) sum[c] += longint'(vals[c]);
        n++;
      end
      if (mv && ordy) mv = 0;
    end
    @(posedge clk); #1;
    check_out();
  endtask

  task automatic all(input int x);
    for (int c = 0; c < CH; c++) vals[c] = x;
  endtask

  task automatic group(input int x, input int beats);
    all(x);
    for (int i = 0; i < beats; i++) cyc(1, 0, 1);
  endtask

  initial begin
    model_reset();
    all(0);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_data", out_data, 0);
    check("rst_out_sat", out_sat, 0);
    @(posedge clk); #1 rst_n = 1;
    cyc(0, 0, 1);
    group(10, 9); all(0); cyc(0, 0, 1);
    group(20, 9); cyc(0, 0, 1);
    group(-20, 9); cyc(0, 0, 1);
    all(0);
    vals[0] = 1 << 30; for (int i = 0; i < 4; i++) cyc(1, 0, 1);
    vals[0] = -(1 << 30); for (int i = 0; i < 4; i++) cyc(1, 0, 1);
    vals[0] = 5; cyc(1, 0, 1);
    all(0); cyc(0, 0, 1);
    // backpressure: result held, beats refused
    group(3, 9);
    all(50);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0);
    group(4, 9); cyc(0, 0, 1);
    // clr flush, including a beat offered with clr
    group(7, 4);
    all(1); cyc(1, 1, 1);
    group(1, 9); cyc(0, 0, 1);
    // async reset mid-group
    group(7, 4);
    rst_n = 0; #1;
    model_reset();
    check("arst_out_valid", out_valid, 0);
    check("arst_in_ready", in_ready, 1);
    @(posedge clk); #1 rst_n = 1;
    group(1, 9); cyc(0, 0, 1);
    // streaming back-to-back groups
    group(1, 9); group(2, 9); group(3, 9); all(0); cyc(0, 0, 1);
    // random phase
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < CH; c++)
        vals[c] = ($urandom_range(0, 7) == 0) ? int'($urandom) : $urandom_range(0, 80) - 40;
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0, $urandom_range(0, 3) != 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sat_accum.md
# sat_accum

Parametrised multi-channel saturating accumulator for the conv datapath. Sums a fixed-length group of wide signed partial products per channel (e.g. one 3x3 kernel window) at full internal precision. Clips each finished sum to a narrow signed output and flags clipped channels. Sits between the multiplier array and the activation/pooling stage, with valid/ready handshakes on both sides.

## Interface
- `IN_W`, 32: signed width of each input operand.
- `OUT_W`, 8: signed width of each output result.
- `CH`, 4: number of parallel channels.
- `ACC_LEN`, 9: beats per accumulation group; must be ≥1.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `clr` input 1: synchronous flush of the partial group.
- `in_valid` input 1: input beat valid.
- `in_ready` output 1: block accepts a beat.
- `in_data` input CH*IN_W: channel c occupies bits [c*IN_W +: IN_W], two's complement.
- `out_valid` output 1: result valid.
- `out_ready` input 1: downstream accepts the result.
- `out_data` output CH*OUT_W: clipped per-channel sums, same packing as `in_data`.
- `out_sat` output CH: per-channel flag, 1 = result was clipped.

## Operation
- Accumulator width ACC_W = IN_W + clog2(ACC_LEN) + 1. Operands are sign-extended to ACC_W, so intermediate sums never wrap.
- Beat fires when in_valid && in_ready. Each fire adds in_data per channel into acc[c] and increments the beat counter `cnt` (0..ACC_LEN-1).
- On the fire with cnt == ACC_LEN-1 the group closes:
  - The final sum is clipped and registered into out_data/out_sat, and out_valid is set.
  - acc is cleared and cnt returns to 0 in the same edge.
  - The next group may start on the following cycle.
- Clip rule per channel:
  - sum > 2^(OUT_W-1)-1 → 2^(OUT_W-1)-1 (127 at default), out_sat = 1.
  - sum < -2^(OUT_W-1) → -2^(OUT_W-1) (-128 at default), out_sat = 1.
  - Otherwise → sum[OUT_W-1:0], out_sat = 0.
- States:
  - IDLE (cnt == 0, no partial sum).
  - ACCUM (0 < cnt < ACC_LEN).
  - Transitions: IDLE→ACCUM on first fire; ACCUM→IDLE on closing fire or clr. With ACC_LEN = 1 every fire closes a group.
- Output register is independent of the FSM. out_valid clears on out_valid && out_ready unless a new closing fire occurs in the same cycle, in which case the new result loads.
- Backpressure: in_ready = !(out_valid && !out_ready).
- `clr`: acc, cnt and state go to 0/IDLE. A beat offered in the same cycle is discarded and is not counted. Does not affect out_valid/out_data/out_sat.

## Timing
- Reset values: in_ready 1, out_valid 0, out_data 0, out_sat 0, acc 0, cnt 0, state IDLE.
- Reset asserted mid-group discards the partial sum and any pending result.
- Latency: out_valid rises 1 cycle after the closing fire.
- Throughput: one beat per cycle while out_ready is held high; one result per ACC_LEN cycles.
- out_data and out_sat are stable while out_valid && !out_ready.
- No combinational path from in_data to out_data. The only combinational path from out_ready is to in_ready.

## Configuration
- `SAT_ACCUM_RELU_EN` defined: negative sums produce out_data = 0 with out_sat = 0. The positive clip still applies.
- `SAT_ACCUM_RELU_EN` undefined: symmetric signed clipping as described in Operation.

## Structure
- Package `sat_accum_pkg` holds:
  - the clog2 function;
  - the ACC_W derivation;
  - the state enum {IDLE, ACCUM}.
- Sub-module `sat_clip` (ACC_W → OUT_W, combinational, value plus flag, honours the RELU macro) is instantiated once per channel via generate.
- The top level holds the counter, FSM, accumulators and output register.

## Test plan
- Default params; 9 beats of +10 on every channel → out_data 90 on all channels, out_sat 0, out_valid exactly 1 cycle after the 9th fire.
- 9 beats of +20 → 127, out_sat 1; 9 beats of -20 → -128, out_sat 1 (RELU build: 0, out_sat 0).
- Beats +2^30 ×4, -2^30 ×4, +5 on ch0 → 5, out_sat 0, proving there is no intermediate wrap.
- Hold out_ready low 3 cycles after a result while in_valid stays high → out_data stable, in_ready 0, no beats counted; next group sums correctly after release.
- clr after 4 beats of +7, then 9 beats of +1 (including one beat offered with clr) → 9; a rst_n pulse after 4 beats gives the same result.
- Continuous streaming, 3 back-to-back groups of +1, +2, +3 with out_ready high → 9, 18, 27, one result every 9 cycles.
